// File: rtl/rst_tagtable.sv
// rst_tagtable: register status table for the Tomasulo/ROB issue stage.
// Each architectural register holds the ROB tag of its in-flight producer
// and a busy flag. Two combinational read ports, one rename write port,
// tag-matched commit clear and a global flush. Entry 0 is never busy.
// Optional checkpoint/restore is enabled by defining RST_CHECKPOINT_EN.
module rst_tagtable #(
  parameter int NREGS  = 32,
  parameter int ADDR_W = 5,
  parameter int TAG_W  = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] Rsaddr_rst,
  output logic [TAG_W-1:0]  Rstag_rst,
  output logic              Rsvalid_rst,
  input  logic [ADDR_W-1:0] Rtaddr_rst,
  output logic [TAG_W-1:0]  Rttag_rst,
  output logic              Rtvalid_rst,
  input  logic              Wen_rst,
  input  logic [ADDR_W-1:0] Waddr_rst,
  input  logic [TAG_W-1:0]  Wdata_rst,
  output logic              Wack_rst,
  input  logic              RB_valid_rst,
  input  logic [ADDR_W-1:0] RB_addr_rst,
  input  logic [TAG_W-1:0]  RB_tag_rst,
  input  logic              Flush_rst,
  output logic [ADDR_W:0]   Busycnt_rst
`ifdef RST_CHECKPOINT_EN
  ,
  input  logic              Ckpt_save_rst,
  input  logic              Ckpt_restore_rst
`endif
);

  logic [NREGS-1:0] r_valid;
  logic [TAG_W-1:0] r_tag [NREGS];
  logic             r_wack;

  logic [NREGS-1:0] w_validNext;
  logic [TAG_W-1:0] w_tagNext [NREGS];
  logic             w_rsOk;
  logic             w_rtOk;
  logic             w_wrOk;
  logic             w_rbOk;
  logic             w_block;
  logic             w_wrAccept;
  logic             w_commitHit;
  logic [ADDR_W:0]  w_busyCnt;

  // Address 0 and addresses beyond the table are never backed by an entry.
  assign w_rsOk = (Rsaddr_rst != '0) && (int'(Rsaddr_rst) < NREGS);
  assign w_rtOk = (Rtaddr_rst != '0) && (int'(Rtaddr_rst) < NREGS);
  assign w_wrOk = (Waddr_rst  != '0) && (int'(Waddr_rst)  < NREGS);
  assign w_rbOk = (RB_addr_rst != '0) && (int'(RB_addr_rst) < NREGS);

`ifdef RST_CHECKPOINT_EN
  // Restore outranks flush, which outranks write/commit.
  assign w_block = Flush_rst | Ckpt_restore_rst;
`else
  assign w_block = Flush_rst;
`endif

  assign w_wrAccept  = Wen_rst && w_wrOk && !w_block;
  assign w_commitHit = RB_valid_rst && w_rbOk && !w_block &&
                       r_valid[RB_addr_rst] && (r_tag[RB_addr_rst] == RB_tag_rst);

  // Next table contents: commit clears first so a same-entry write overrides it.
  always_comb begin
    w_validNext = r_valid;
    w_tagNext   = r_tag;
    if (w_commitHit) w_validNext[RB_addr_rst] = 1'b0;
    if (w_wrAccept) begin
      w_validNext[Waddr_rst] = 1'b1;
      w_tagNext[Waddr_rst]   = Wdata_rst;
    end
    if (Flush_rst) w_validNext = '0;
  end

`ifdef RST_CHECKPOINT_EN
  logic [NREGS-1:0] r_shValid;
  logic [TAG_W-1:0] r_shTag [NREGS];
  logic             w_shHit;

  assign w_shHit = RB_valid_rst && w_rbOk && !w_block &&
                   r_shValid[RB_addr_rst] && (r_shTag[RB_addr_rst] == RB_tag_rst);

  // Shadow snapshot; committed producers are retired from it so restore cannot revive them.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_shValid <= '0;
      for (int i = 0; i < NREGS; i++) r_shTag[i] <= '0;
    end else if (!Ckpt_restore_rst) begin
      if (Ckpt_save_rst) begin
        r_shValid <= w_validNext;
        r_shTag   <= w_tagNext;
      end else if (w_shHit) begin
        r_shValid[RB_addr_rst] <= 1'b0;
      end
    end
  end

  // Table state register, loaded from the shadow on restore.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_valid <= '0;
      for (int i = 0; i < NREGS; i++) r_tag[i] <= '0;
    end else if (Ckpt_restore_rst) begin
      r_valid <= r_shValid;
      r_tag   <= r_shTag;
    end else begin
      r_valid <= w_validNext;
      r_tag   <= w_tagNext;
    end
  end
`else
  // Table state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_valid <= '0;
      for (int i = 0; i < NREGS; i++) r_tag[i] <= '0;
    end else begin
      r_valid <= w_validNext;
      r_tag   <= w_tagNext;
    end
  end
`endif

  // Write acknowledge, one cycle after an accepted rename.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_wack <= 1'b0;
    else        r_wack <= w_wrAccept;
  end

  assign Wack_rst = r_wack;

  // Read ports return pre-edge state; unbacked addresses read as free with tag 0.
  always_comb begin
    Rstag_rst   = '0;
    Rsvalid_rst = 1'b0;
    Rttag_rst   = '0;
    Rtvalid_rst = 1'b0;
    if (w_rsOk) begin
      Rstag_rst   = r_tag[Rsaddr_rst];
      Rsvalid_rst = r_valid[Rsaddr_rst];
    end
    if (w_rtOk) begin
      Rttag_rst   = r_tag[Rtaddr_rst];
      Rtvalid_rst = r_valid[Rtaddr_rst];
    end
  end

  // Count of busy entries.
  always_comb begin
    w_busyCnt = '0;
    for (int i = 0; i < NREGS; i++) w_busyCnt = w_busyCnt + (ADDR_W+1)'(r_valid[i]);
  end

  assign Busycnt_rst = w_busyCnt;

endmodule

// File: doc/rst_tagtable.md
Name: rst_tagtable

Overview:
Parametrised register status table for the Tomasulo/ROB issue stage. It holds, per architectural register, the reorder-buffer tag of the in-flight producer and a busy flag. It provides two read ports for source renaming, one rename-write port, tag-matched commit clear, a global flush for mispredict recovery, and an optional checkpoint/restore. It sits between decode/issue and the reorder buffer and supersedes the fixed 32x5 table.

Parameters:
NREGS, 32, number of architectural registers (entry 0 hard-wired not-busy)
ADDR_W, 5, register address width; NREGS <= 2**ADDR_W
TAG_W, 5, ROB tag width

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
Rsaddr_rst  in  ADDR_W  source-s register address
Rstag_rst  out  TAG_W  tag of Rs producer
Rsvalid_rst  out  1  Rs busy (tag valid)
Rtaddr_rst  in  ADDR_W  source-t register address
Rttag_rst  out  TAG_W  tag of Rt producer
Rtvalid_rst  out  1  Rt busy
Wen_rst  in  1  rename write request
Waddr_rst  in  ADDR_W  destination register being renamed
Wdata_rst  in  TAG_W  ROB tag assigned to destination
Wack_rst  out  1  registered: write accepted last cycle
RB_valid_rst  in  1  ROB commit strobe
RB_addr_rst  in  ADDR_W  destination register of committing entry
RB_tag_rst  in  TAG_W  tag of committing entry
Flush_rst  in  1  mispredict flush: clear all busy bits
Busycnt_rst  out  ADDR_W+1  number of busy entries
Ckpt_save_rst  in  1  (RST_CHECKPOINT_EN only) snapshot table
Ckpt_restore_rst  in  1  (RST_CHECKPOINT_EN only) restore snapshot

Behaviour:
- Reset (reset=0, async): all valid=0, all tags=0, Wack_rst=0. Rstag_rst/Rttag_rst=0, Rsvalid_rst/Rtvalid_rst=0, Busycnt_rst=0. Outputs follow within the same cycle; reset mid-operation discards all state.
- Reads: combinational from registered state, zero latency. Reads in the same cycle as a write or commit return pre-edge contents (no bypass). Address 0 or address >= NREGS reads tag 0, valid 0.
- Rename write: on the edge with Wen_rst=1, 0 < Waddr_rst < NREGS and Flush_rst=0, set entry tag=Wdata_rst and valid=1, overwriting any existing tag (WAW). Wack_rst=1 on the following cycle, otherwise 0. Writes to reg 0, out-of-range addresses, or during a flush are dropped, and Wack_rst=0.
- Commit: on the edge with RB_valid_rst=1, clear valid of RB_addr_rst only if that entry is valid and its tag == RB_tag_rst. A tag mismatch (register re-renamed since) leaves the entry unchanged. The stored tag is left unchanged.
- Same-entry write and commit in one cycle: the write wins (new tag, valid=1). Different entries: both take effect.
- Flush_rst=1: next edge all valid=0; write and commit are ignored that cycle; tags are retained.
- Busycnt_rst: popcount of the valid bits, combinational from state, range 0..NREGS-1.
- No internal FSM beyond per-entry valid state: {free -> busy on write; busy -> free on matching commit or flush; busy -> busy(new tag) on write}.

Optional Feature:
RST_CHECKPOINT_EN. When defined, adds Ckpt_save_rst, Ckpt_restore_rst and a shadow copy of the valid and tag arrays.
- Save: the shadow captures the table's next state, i.e. the result of this edge's write and commit.
- Matching commits also clear the corresponding shadow valid bit, so a restore never resurrects a committed tag.
- Restore: the table is loaded from the shadow on the next edge.
- Priority: restore > flush > write/commit. A save in the same cycle as a restore is ignored.
- Shadow is cleared on reset.
When not defined: the ports and shadow do not exist and behaviour is exactly as above.

Test Plan:
1. Reset held low 2 cycles, then released; sweep Rs/Rt addresses 0..31 -> all tags 0, valid 0, Busycnt_rst=0.
2. Write reg 7 tag 12, then read Rs=7 in the same cycle and again the next cycle -> valid 0 in the same cycle; tag 12, valid 1 next cycle; Wack_rst=1 for one cycle; Busycnt_rst=1.
3. Write reg 0 tag 3 -> Wack_rst=0, Rs=0 reads valid 0, Busycnt_rst unchanged.
4. Reg 7 holds tag 12; rewrite tag 20; commit (7,12) -> reg 7 stays tag 20 valid. Then commit (7,20) -> valid 0.
5. Same cycle: write reg 9 tag 4 and commit (9,old tag 2) -> reg 9 tag 4 valid. Write regs 1..5 then Flush_rst -> Busycnt_rst 5 -> 0, write during the flush dropped.
6. (RST_CHECKPOINT_EN) Write reg 3 tag 1 with save; write reg 4 tag 2; commit (3,1); restore -> reg 3 free, reg 4 free, Busycnt_rst=0.
